// File: rtl/haar_database_sequencer_pkg.sv
// Shared definitions for the Haar database sequencer and the stage classifier.
package haar_database_sequencer_pkg;

    // Words per tree record: 3 rects x 5 words + threshold + left + right.
    localparam int unsigned NumClassifiers = 18;
    // Trailing words per stage: stage threshold, parent, next.
    localparam int unsigned NumStageWords  = 3;

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StTree,
        StStage,
        StResult,
        StDone
    } state_e;

endpackage

// File: rtl/haar_database_sequencer_counter.sv
// Wrapping up-counter: runs 0..max_size-1 while enabled, flags the final count.
module haar_database_sequencer_counter #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] max_size,
    output logic [WIDTH-1:0] ctr_out,
    output logic             end_count
);

    logic [WIDTH-1:0] ctr_q, ctr_d;

    assign end_count = enable && (ctr_q == max_size - WIDTH'(1));
    assign ctr_out   = ctr_q;

    // Next count: clear has priority, wrap to zero on the final count.
    always_comb begin
        ctr_d = ctr_q;
        if (clear) begin
            ctr_d = '0;
        end else if (enable) begin
            ctr_d = end_count ? '0 : ctr_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/haar_database_sequencer.sv
// Walks the packed Haar cascade ROM and streams it into the stage classifier.
module haar_database_sequencer
    import haar_database_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_12   = 12,
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned NUM_CLASSIFIERS = NumClassifiers,
    parameter int unsigned NUM_STAGE_WORDS = NumStageWords,
    parameter int unsigned NUM_STAGES      = 25,
    parameter int unsigned RESULT_LATENCY  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_start,
    input  logic                     i_stage_pass,
    output logic [ADDR_WIDTH-1:0]    o_rom_addr,
    output logic                     o_rom_rd,
    input  logic [DATA_WIDTH_12-1:0] i_rom_data,
    output logic                     o_valid,
    output logic [DATA_WIDTH_12-1:0] o_data,
    output logic [DATA_WIDTH_12-1:0] o_index_classifier,
    output logic [DATA_WIDTH_12-1:0] o_index_tree,
    output logic [DATA_WIDTH_12-1:0] o_index_database,
    output logic                     o_end_single_classifier,
    output logic                     o_end_tree,
    output logic                     o_end_all_classifier,
    output logic                     o_end_database,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_face
);

    localparam int unsigned DW = DATA_WIDTH_12;
    localparam int unsigned AW = ADDR_WIDTH;

    // Per-word side information, built at issue time and carried alongside the read.
    typedef struct packed {
        logic          stream;
        logic [DW-1:0] cls;
        logic [DW-1:0] tree;
        logic [DW-1:0] db;
        logic          end_single;
        logic          end_tree;
        logic          end_all;
        logic          end_db;
    } meta_t;

    state_e        state_q, state_d;
    logic          rom_rd_q, rom_rd_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [AW-1:0] next_addr_q, next_addr_d;
    logic [DW-1:0] tree_q, tree_d;
    logic [DW-1:0] tree_count_q, tree_count_d;
    logic [DW-1:0] stage_q, stage_d;
    logic [7:0]    res_q, res_d;
    logic          face_q, face_d;
    meta_t         iss_q, iss_d;
    meta_t         out_q;

    logic          ctr_clr, word_en, word_end, sw_en, sw_end, last_tree;
    logic [DW-1:0] word_idx, sw_idx;

    haar_database_sequencer_counter #(
        .WIDTH (DW)
    ) u_word_ctr (
        .clk       (clk),
        .reset     (reset),
        .clear     (ctr_clr),
        .enable    (word_en),
        .max_size  (DW'(NUM_CLASSIFIERS)),
        .ctr_out   (word_idx),
        .end_count (word_end)
    );

    haar_database_sequencer_counter #(
        .WIDTH (DW)
    ) u_stage_word_ctr (
        .clk       (clk),
        .reset     (reset),
        .clear     (ctr_clr),
        .enable    (sw_en),
        .max_size  (DW'(NUM_STAGE_WORDS)),
        .ctr_out   (sw_idx),
        .end_count (sw_end)
    );

    assign last_tree = (tree_q == tree_count_q - DW'(1));

    // Next-state, ROM read issue and per-word side information.
    always_comb begin
        state_d      = state_q;
        rom_rd_d     = 1'b0;
        rom_addr_d   = rom_addr_q;
        next_addr_d  = next_addr_q;
        tree_d       = tree_q;
        tree_count_d = tree_count_q;
        stage_d      = stage_q;
        res_d        = res_q;
        face_d       = face_q;
        iss_d        = '0;
        ctr_clr      = 1'b0;
        word_en      = 1'b0;
        sw_en        = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_start) begin
                    rom_rd_d    = 1'b1;
                    rom_addr_d  = '0;
                    next_addr_d = AW'(1);
                    stage_d     = '0;
                    tree_d      = '0;
                    face_d      = 1'b0;
                    ctr_clr     = 1'b1;
                    state_d     = StHeader;
                end
            end
            StHeader: begin
                // The header read is in flight while the strobe is high; data lands next cycle.
                if (!rom_rd_q) begin
                    tree_count_d = i_rom_data;
                    tree_d       = '0;
                    state_d      = (i_rom_data == '0) ? StStage : StTree;
                end
            end
            StTree: begin
                rom_rd_d         = 1'b1;
                rom_addr_d       = next_addr_q;
                next_addr_d      = next_addr_q + AW'(1);
                word_en          = 1'b1;
                iss_d.stream     = 1'b1;
                iss_d.cls        = word_idx;
                iss_d.tree       = tree_q;
                iss_d.db         = stage_q;
                iss_d.end_single = word_end;
                iss_d.end_tree   = word_end && last_tree;
                if (word_end) begin
                    if (last_tree) begin
                        state_d = StStage;
                    end else begin
                        tree_d = tree_q + DW'(1);
                    end
                end
            end
            StStage: begin
                rom_rd_d      = 1'b1;
                rom_addr_d    = next_addr_q;
                next_addr_d   = next_addr_q + AW'(1);
                sw_en         = 1'b1;
                iss_d.stream  = 1'b1;
                iss_d.cls     = sw_idx;
                iss_d.tree    = tree_q;
                iss_d.db      = stage_q;
                iss_d.end_all = 1'b1;
                iss_d.end_db  = sw_end;
                if (sw_end) begin
                    res_d   = '0;
                    state_d = StResult;
                end
            end
            StResult: begin
                // Entered one cycle before the last stage word is valid, hence the +1.
                if (res_q == 8'(RESULT_LATENCY + 1)) begin
                    if (!i_stage_pass) begin
                        face_d  = 1'b0;
                        state_d = StDone;
                    end else if (stage_q == DW'(NUM_STAGES - 1)) begin
                        face_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        stage_d     = stage_q + DW'(1);
                        rom_rd_d    = 1'b1;
                        rom_addr_d  = next_addr_q;
                        next_addr_d = next_addr_q + AW'(1);
                        state_d     = StHeader;
                    end
                end else begin
                    res_d = res_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counters, ROM interface and the two-deep side-information pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            rom_rd_q     <= 1'b0;
            rom_addr_q   <= '0;
            next_addr_q  <= '0;
            tree_q       <= '0;
            tree_count_q <= '0;
            stage_q      <= '0;
            res_q        <= '0;
            face_q       <= 1'b0;
            iss_q        <= '0;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            rom_rd_q     <= rom_rd_d;
            rom_addr_q   <= rom_addr_d;
            next_addr_q  <= next_addr_d;
            tree_q       <= tree_d;
            tree_count_q <= tree_count_d;
            stage_q      <= stage_d;
            res_q        <= res_d;
            face_q       <= face_d;
            iss_q        <= iss_d;
            out_q        <= iss_q;
        end
    end

    assign o_rom_rd                = rom_rd_q;
    assign o_rom_addr              = rom_addr_q;
    assign o_valid                 = out_q.stream;
    assign o_data                  = out_q.stream ? i_rom_data : '0;
    assign o_index_classifier      = out_q.cls;
    assign o_index_tree            = out_q.tree;
    assign o_index_database        = out_q.db;
    assign o_end_single_classifier = out_q.end_single;
    assign o_end_tree              = out_q.end_tree;
    assign o_end_all_classifier    = out_q.end_all;
    assign o_end_database          = out_q.end_db;
    assign o_busy                  = (state_q != StIdle);
    assign o_done                  = (state_q == StDone);
    assign o_face                  = face_q;

endmodule

// File: tb/tb_haar_database_sequencer.sv
// Randomized bench for haar_database_sequencer against a stream-level reference model.
module tb_haar_database_sequencer;

    localparam int DW  = 12;
    localparam int AW  = 16;
    localparam int NC  = 18;
    localparam int NSW = 3;
    localparam int NS  = 2;
    localparam int RL  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_start;
    logic          i_stage_pass;
    logic [AW-1:0] o_rom_addr;
    logic          o_rom_rd;
    logic [DW-1:0] i_rom_data;
    logic          o_valid;
    logic [DW-1:0] o_data, o_index_classifier, o_index_tree, o_index_database;
    logic          o_end_single_classifier, o_end_tree, o_end_all_classifier, o_end_database;
    logic          o_busy, o_done, o_face;

    haar_database_sequencer #(
        .DATA_WIDTH_12   (DW),
        .ADDR_WIDTH      (AW),
        .NUM_CLASSIFIERS (NC),
        .NUM_STAGE_WORDS (NSW),
        .NUM_STAGES      (NS),
        .RESULT_LATENCY  (RL)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .i_start                 (i_start),
        .i_stage_pass            (i_stage_pass),
        .o_rom_addr              (o_rom_addr),
        .o_rom_rd                (o_rom_rd),
        .i_rom_data              (i_rom_data),
        .o_valid                 (o_valid),
        .o_data                  (o_data),
        .o_index_classifier      (o_index_classifier),
        .o_index_tree            (o_index_tree),
        .o_index_database        (o_index_database),
        .o_end_single_classifier (o_end_single_classifier),
        .o_end_tree              (o_end_tree),
        .o_end_all_classifier    (o_end_all_classifier),
        .o_end_database          (o_end_database),
        .o_busy                  (o_busy),
        .o_done                  (o_done),
        .o_face                  (o_face)
    );

    always #5 clk = ~clk;

    // ROM with one cycle of read latency.
    logic [DW-1:0] rom [0:255];
    logic [DW-1:0] rom_q = '0;
    always @(posedge clk) if (o_rom_rd) rom_q <= rom[o_rom_addr[7:0]];
    assign i_rom_data = rom_q;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [DW-1:0] cls;
        logic [DW-1:0] tree;
        logic [DW-1:0] db;
        logic          es;
        logic          et;
        logic          ea;
        logic          ed;
    } beat_t;

    beat_t         obs_beats[$];
    beat_t         exp_beats[$];
    logic [AW-1:0] obs_addrs[$];
    logic [AW-1:0] exp_addrs[$];
    int            done_cnt = 0;
    logic          face_at_done = 1'b0;
    bit            exp_face;
    int            tree_cnt[NS];
    bit            verdict[NS];
    int            n_cmp = 0;
    int            n_bad = 0;

    // Passive monitor of the stream, ROM reads and completions.
    always @(negedge clk) begin
        if (o_valid) begin
            obs_beats.push_back(beat_t'{data: o_data, cls: o_index_classifier,
                tree: o_index_tree, db: o_index_database, es: o_end_single_classifier,
                et: o_end_tree, ea: o_end_all_classifier, ed: o_end_database});
        end
        if (o_rom_rd) obs_addrs.push_back(o_rom_addr);
        if (o_done) begin
            done_cnt++;
            face_at_done = o_face;
        end
    end

    // Classifier stand-in: drive the verdict only in the cycle it must be sampled, its
    // inverse otherwise, RL cycles after the last stage word.
    initial begin
        bit w;
        i_stage_pass = 1'b0;
        forever begin
            @(negedge clk);
            if (o_valid && o_end_database) begin
                w = verdict[o_index_database[0]];
                i_stage_pass = !w;
                repeat (RL) @(posedge clk);
                #1 i_stage_pass = w;
                @(posedge clk);
                #1 i_stage_pass = !w;
            end
        end
    end

    task automatic build_rom();
        int base;
        for (int i = 0; i < 256; i++) rom[i] = DW'($urandom_range(0, 4095));
        base = 0;
        for (int s = 0; s < NS; s++) begin
            rom[base] = DW'(tree_cnt[s]);
            base += 1 + tree_cnt[s] * NC + NSW;
        end
    endtask

    // Reference: walk the database layout and list every read and streamed word.
    task automatic build_expected();
        int a, base, tc;
        exp_beats.delete();
        exp_addrs.delete();
        exp_face = 1'b0;
        base = 0;
        for (int s = 0; s < NS; s++) begin
            tc = tree_cnt[s];
            exp_addrs.push_back(AW'(base));
            a = base + 1;
            for (int t = 0; t < tc; t++) begin
                for (int w = 0; w < NC; w++) begin
                    exp_beats.push_back(beat_t'{data: rom[a], cls: DW'(w), tree: DW'(t),
                        db: DW'(s), es: (w == NC - 1), et: (w == NC - 1) && (t == tc - 1),
                        ea: 1'b0, ed: 1'b0});
                    exp_addrs.push_back(AW'(a));
                    a++;
                end
            end
            for (int k = 0; k < NSW; k++) begin
                exp_beats.push_back(beat_t'{data: rom[a], cls: DW'(k),
                    tree: DW'((tc == 0) ? 0 : tc - 1), db: DW'(s), es: 1'b0, et: 1'b0,
                    ea: 1'b1, ed: (k == NSW - 1)});
                exp_addrs.push_back(AW'(a));
                a++;
            end
            base = a;
            if (!verdict[s]) break;
            if (s == NS - 1) exp_face = 1'b1;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
    endtask

    // One full pass, optionally with a second i_start 'poke' cycles into it.
    task automatic run_and_check(input string name, input int poke);
        int  bb, ab, db;
        bit  got;
        build_rom();
        build_expected();
        bb = obs_beats.size();
        ab = obs_addrs.size();
        db = done_cnt;
        pulse_start();
        if (poke > 0) begin
            repeat (poke) @(posedge clk);
            #1;
            n_cmp++;
            if (o_busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s busy_at_poke: got %b want 1", name, o_busy);
            end
            i_start = 1'b1;
            @(posedge clk);
            #1 i_start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            if (done_cnt != db) begin
                got = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s done_timeout: no o_done within 600 cycles", name);
        end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_beats.size() - bb != exp_beats.size()) begin
            n_bad++;
            $display("FAIL %s beat_count: got %0d want %0d", name, obs_beats.size() - bb,
                     exp_beats.size());
        end
        for (int i = 0; i < exp_beats.size(); i++) begin
            if (bb + i < obs_beats.size()) begin
                n_cmp++;
                if (obs_beats[bb + i] !== exp_beats[i]) begin
                    n_bad++;
                    $display("FAIL %s beat[%0d]: got %h want %h", name, i, obs_beats[bb + i],
                             exp_beats[i]);
                end
            end
        end
        n_cmp++;
        if (obs_addrs.size() - ab != exp_addrs.size()) begin
            n_bad++;
            $display("FAIL %s read_count: got %0d want %0d", name, obs_addrs.size() - ab,
                     exp_addrs.size());
        end
        for (int i = 0; i < exp_addrs.size(); i++) begin
            if (ab + i < obs_addrs.size()) begin
                n_cmp++;
                if (obs_addrs[ab + i] !== exp_addrs[i]) begin
                    n_bad++;
                    $display("FAIL %s read_addr[%0d]: got %0d want %0d", name, i,
                             obs_addrs[ab + i], exp_addrs[i]);
                end
            end
        end
        n_cmp++;
        if (done_cnt - db != 1) begin
            n_bad++;
            $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - db);
        end
        n_cmp++;
        if (face_at_done !== exp_face) begin
            n_bad++;
            $display("FAIL %s face_at_done: got %b want %b", name, face_at_done, exp_face);
        end
        n_cmp++;
        if (o_face !== exp_face || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle_after: face %b busy %b want face %b busy 0", name, o_face,
                     o_busy, exp_face);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({o_rom_addr, o_rom_rd, o_valid, o_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_rom_stream: got addr %0d rd %b valid %b data %h want 0",
                     o_rom_addr, o_rom_rd, o_valid, o_data);
        end
        n_cmp++;
        if ({o_index_classifier, o_index_tree, o_index_database, o_end_single_classifier,
             o_end_tree, o_end_all_classifier, o_end_database} !== '0) begin
            n_bad++;
            $display("FAIL reset_indices: got nonzero index/marker, want 0");
        end
        n_cmp++;
        if ({o_busy, o_done, o_face} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_status: got %b want 000", {o_busy, o_done, o_face});
        end
        reset = 1'b0;
    endtask

    task automatic test_two_stage_pass();
        tree_cnt[0] = 2; tree_cnt[1] = 1;
        verdict[0] = 1'b1; verdict[1] = 1'b1;
        run_and_check("two_stage_pass", 0);
    endtask

    task automatic test_reject();
        tree_cnt[0] = $urandom_range(1, 3); tree_cnt[1] = $urandom_range(0, 3);
        verdict[0] = 1'b0; verdict[1] = 1'b1;
        run_and_check("reject_stage0", 0);
    endtask

    task automatic test_zero_trees();
        tree_cnt[0] = 0; tree_cnt[1] = $urandom_range(1, 2);
        verdict[0] = 1'b1; verdict[1] = $urandom_range(0, 1);
        run_and_check("zero_trees", 0);
    endtask

    task automatic test_busy_start();
        tree_cnt[0] = 1; tree_cnt[1] = 1;
        verdict[0] = 1'b1; verdict[1] = 1'b1;
        run_and_check("busy_start", $urandom_range(3, 30));
    endtask

    task automatic test_reset_start();
        @(posedge clk);
        #1 reset = 1'b1; i_start = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; i_start = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b0 || o_rom_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_wins: got busy %b rd %b want 0 0", o_busy, o_rom_rd);
        end
    endtask

    task automatic test_reset_mid_tree();
        int  bb, db;
        bit  got;
        tree_cnt[0] = 2; tree_cnt[1] = 1;
        verdict[0] = 1'b1; verdict[1] = 1'b1;
        build_rom();
        bb = obs_beats.size();
        db = done_cnt;
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (obs_beats.size() - bb >= 11) begin
                got = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL mid_reset_beat_timeout: beat 10 not seen within 200 cycles");
        end
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({o_rom_addr, o_rom_rd, o_valid, o_data, o_index_classifier, o_index_tree,
             o_index_database, o_end_single_classifier, o_end_tree, o_end_all_classifier,
             o_end_database, o_busy, o_done, o_face} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got rd %b valid %b busy %b addr %0d want all 0",
                     o_rom_rd, o_valid, o_busy, o_rom_addr);
        end
        reset = 1'b0;
        repeat (60) @(posedge clk);
        n_cmp++;
        if (done_cnt != db) begin
            n_bad++;
            $display("FAIL mid_reset_no_done: got %0d done pulses want 0", done_cnt - db);
        end
        run_and_check("after_reset", 0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            tree_cnt[0] = $urandom_range(1, 3); tree_cnt[1] = $urandom_range(0, 3);
            verdict[0] = 1'b1; verdict[1] = 1'b1;
            run_and_check($sformatf("back_to_back%0d", r), 0);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            for (int s = 0; s < NS; s++) begin
                tree_cnt[s] = $urandom_range(0, 3);
                verdict[s]  = $urandom_range(0, 1);
            end
            run_and_check($sformatf("random%0d", r),
                          ($urandom_range(0, 1) == 1) ? $urandom_range(3, 8) : 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        i_start = 1'b0;
        test_reset();
        test_two_stage_pass();
        test_reject();
        test_zero_trees();
        test_busy_start();
        test_reset_start();
        test_reset_mid_tree();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
